// File: rtl/safe_softmax_max_sub.sv
// Row-buffering max-subtraction stage: stores one row of signed scores while
// tracking the row maximum, then replays each score as clamp(x - max) for the exp stage.
module safe_softmax_max_sub #(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 16
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic           I_VALID,
    output logic           O_READY,
    input  logic [D_W-1:0] I_DATA,
    output logic           O_VALID,
    input  logic           I_READY,
    output logic [D_W-1:0] O_DATA,
    output logic           O_LAST
);

    localparam int ADDR_W = $clog2(ROW_LEN);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0]  RD_END  = CNT_W'(ROW_LEN);

    // Most negative emitted value is -(2^(D_W-1)-1); the all-ones-MSB code is never produced.
    localparam logic signed [D_W:0] CLAMP_MIN_W = {2'b11, {(D_W-2){1'b0}}, 1'b1};
    localparam logic [D_W-1:0]      CLAMP_MIN_D = {1'b1, {(D_W-2){1'b0}}, 1'b1};

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [D_W-1:0]      max_q, max_d;
    logic                o_valid_q, o_valid_d;
    logic [D_W-1:0]      o_data_q, o_data_d;
    logic                o_last_q, o_last_d;
    logic                wr_en_s;
    logic                accept_s;
    logic [D_W-1:0]      row_mem_q [ROW_LEN];

    function automatic logic [D_W-1:0] sub_clamp(input logic [D_W-1:0] x,
                                                 input logic [D_W-1:0] m);
        logic signed [D_W:0] diff;
        diff = $signed({x[D_W-1], x}) - $signed({m[D_W-1], m});
        if (diff < CLAMP_MIN_W) begin
            sub_clamp = CLAMP_MIN_D;
        end else begin
            sub_clamp = diff[D_W-1:0];
        end
    endfunction

    assign O_READY  = (state_q == S_LOAD) && I_RST_N;
    assign accept_s = I_VALID && O_READY;
    assign O_VALID  = o_valid_q;
    assign O_DATA   = o_data_q;
    assign O_LAST   = o_last_q;

    // Next-state logic for the load/drain FSM, counters, running max and output register.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        max_d     = max_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;
        wr_en_s   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    // First element seeds the max so the previous row's max never leaks in.
                    if (wr_cnt_q == '0) begin
                        max_d = I_DATA;
                    end else if ($signed(I_DATA) > $signed(max_q)) begin
                        max_d = I_DATA;
                    end else begin
                        max_d = max_q;
                    end
                    if (wr_cnt_q == WR_LAST) begin
                        wr_cnt_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            S_DRAIN: begin
                if (o_valid_q && I_READY && o_last_q) begin
                    o_valid_d = 1'b0;
                    rd_cnt_d  = '0;
                    state_d   = S_LOAD;
                end else if ((!o_valid_q || I_READY) && (rd_cnt_q < RD_END)) begin
                    o_valid_d = 1'b1;
                    o_data_d  = sub_clamp(row_mem_q[rd_cnt_q[ADDR_W-1:0]], max_q);
                    o_last_d  = (rd_cnt_q == RD_LAST);
                    rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                end else begin
                    o_valid_d = o_valid_q;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            state_q   <= S_LOAD;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            max_q     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            max_q     <= max_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
        end
    end

    // Row buffer; contents are deliberately left unreset.
    always_ff @(posedge I_CLK) begin
        if (wr_en_s) begin
            row_mem_q[wr_cnt_q] <= I_DATA;
        end
    end

endmodule
